// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with a built-in transmit FIFO.
// A valid/ready write port fills the FIFO. Frames leave back-to-back for as
// long as the FIFO holds data. Frame format is start, DATA_BITS data bits sent
// LSB first, an optional parity bit, then STOP_BITS stop bits.
// Optional feature: define UART_TX_BREAK_EN to add the tx_break input. A break
// holds the line low once the current frame has completed. After the break is
// released, the line is high for one full bit time before the next start bit.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          uart_tx
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                          tx_break
`endif
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int BW  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5,
    ST_BGAP   = 3'd6
  } state_t;

  // Parity over the data bits. Odd parity inverts the XOR so that the total
  // number of ones, including the parity bit, becomes odd.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    parity_bit = (^d) ^ (PARITY == 1);
  endfunction

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]        level_r;
  logic                 push_s, pop_s, full_s, empty_s;
  logic [DATA_BITS-1:0] head_s;

  // Transmit engine state
  state_t               state_r, state_nxt_s;
  logic [CW-1:0]        baud_r, baud_nxt_s;
  logic [BW-1:0]        bit_r, bit_nxt_s;
  logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
  logic                 par_r, par_nxt_s;
  logic                 tx_nxt_s, busy_nxt_s, done_nxt_s;
  logic                 bit_end_s, launch_s;

  assign full_s     = (level_r == LW'(FIFO_DEPTH));
  assign empty_s    = (level_r == {LW{1'b0}});
  assign tx_ready   = ~full_s;
  assign fifo_level = level_r;
  assign push_s     = tx_valid & ~full_s;
  assign head_s     = mem_r[rd_ptr_r];
  assign bit_end_s  = (baud_r == CW'(DIV - 1));

  // FIFO data array: stores the accepted word at the write pointer
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // FIFO pointers and occupancy. A simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Engine registers. The line, busy and done outputs are driven directly from flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      baud_r  <= {CW{1'b0}};
      bit_r   <= {BW{1'b0}};
      shift_r <= {DATA_BITS{1'b0}};
      par_r   <= 1'b0;
      uart_tx <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      baud_r  <= baud_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
      par_r   <= par_nxt_s;
      uart_tx <= tx_nxt_s;
      busy    <= busy_nxt_s;
      tx_done <= done_nxt_s;
    end
  end

  // Next-state logic. A "launch" decides what follows idle, a final stop bit, or a
  // break gap: a break, the next queued word with no idle gap, or idle.
  always_comb begin
    state_nxt_s = state_r;
    baud_nxt_s  = baud_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    par_nxt_s   = par_r;
    tx_nxt_s    = uart_tx;
    busy_nxt_s  = busy;
    done_nxt_s  = 1'b0;
    pop_s       = 1'b0;
    launch_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        launch_s = 1'b1;
      end
      ST_START: begin
        if (bit_end_s) begin
          baud_nxt_s  = {CW{1'b0}};
          bit_nxt_s   = {BW{1'b0}};
          tx_nxt_s    = shift_r[0];
          state_nxt_s = ST_DATA;
        end else begin
          baud_nxt_s = baud_r + CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          baud_nxt_s = {CW{1'b0}};
          if (bit_r == BW'(DATA_BITS - 1)) begin
            bit_nxt_s = {BW{1'b0}};
            if (PARITY != 0) begin
              tx_nxt_s    = par_r;
              state_nxt_s = ST_PARITY;
            end else begin
              tx_nxt_s    = 1'b1;
              state_nxt_s = ST_STOP;
            end
          end else begin
            bit_nxt_s   = bit_r + BW'(1);
            shift_nxt_s = {1'b0, shift_r[DATA_BITS-1:1]};
            tx_nxt_s    = shift_r[1];
          end
        end else begin
          baud_nxt_s = baud_r + CW'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          baud_nxt_s  = {CW{1'b0}};
          bit_nxt_s   = {BW{1'b0}};
          tx_nxt_s    = 1'b1;
          state_nxt_s = ST_STOP;
        end else begin
          baud_nxt_s = baud_r + CW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          baud_nxt_s = {CW{1'b0}};
          if (bit_r == BW'(STOP_BITS - 1)) begin
            done_nxt_s = 1'b1;
            launch_s   = 1'b1;
          end else begin
            bit_nxt_s = bit_r + BW'(1);
          end
        end else begin
          baud_nxt_s = baud_r + CW'(1);
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        baud_nxt_s = {CW{1'b0}};
        if (tx_break) begin
          tx_nxt_s = 1'b0;
        end else begin
          tx_nxt_s    = 1'b1;
          state_nxt_s = ST_BGAP;
        end
      end
      ST_BGAP: begin
        if (bit_end_s) begin
          launch_s = 1'b1;
        end else begin
          baud_nxt_s = baud_r + CW'(1);
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
        baud_nxt_s  = {CW{1'b0}};
        tx_nxt_s    = 1'b1;
        busy_nxt_s  = 1'b0;
      end
    endcase

    if (launch_s) begin
      baud_nxt_s = {CW{1'b0}};
      bit_nxt_s  = {BW{1'b0}};
`ifdef UART_TX_BREAK_EN
      if (tx_break) begin
        tx_nxt_s    = 1'b0;
        busy_nxt_s  = 1'b1;
        state_nxt_s = ST_BREAK;
      end else
`endif
      if (!empty_s) begin
        pop_s       = 1'b1;
        shift_nxt_s = head_s;
        par_nxt_s   = parity_bit(head_s);
        tx_nxt_s    = 1'b0;
        busy_nxt_s  = 1'b1;
        state_nxt_s = ST_START;
      end else begin
        tx_nxt_s    = 1'b1;
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo.
// Four instances cover 8N1/depth 16, 7E2, 7O2 and 8N1/depth 4. Each has its
// own write port; all share clk and rstn. Every accepted word is pushed onto
// the scoreboard. A line monitor rebuilds the expected frame, checks it clock
// by clock, and decodes the data bits. The break test is compiled only when
// UART_TX_BREAK_EN is defined.
module tb_uart_tx_fifo;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  tdata [4];
  logic [3:0]  tvalid;
  logic [3:0]  rdy_v, busy_v, done_v, line_v;
  logic [4:0]  lvl0, lvl1, lvl2;
  logic [2:0]  lvl3;
  logic        brk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  sb_q [$];
  logic        last_par;

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
    .clk(clk), .rstn(rstn), .tx_data(tdata[0]), .tx_valid(tvalid[0]),
    .tx_ready(rdy_v[0]), .fifo_level(lvl0), .busy(busy_v[0]), .tx_done(done_v[0]),
    .uart_tx(line_v[0])
`ifdef UART_TX_BREAK_EN
    , .tx_break(brk)
`endif
  );

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) u_b (
    .clk(clk), .rstn(rstn), .tx_data(tdata[1][6:0]), .tx_valid(tvalid[1]),
    .tx_ready(rdy_v[1]), .fifo_level(lvl1), .busy(busy_v[1]), .tx_done(done_v[1]),
    .uart_tx(line_v[1])
`ifdef UART_TX_BREAK_EN
    , .tx_break(1'b0)
`endif
  );

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) u_c (
    .clk(clk), .rstn(rstn), .tx_data(tdata[2][6:0]), .tx_valid(tvalid[2]),
    .tx_ready(rdy_v[2]), .fifo_level(lvl2), .busy(busy_v[2]), .tx_done(done_v[2]),
    .uart_tx(line_v[2])
`ifdef UART_TX_BREAK_EN
    , .tx_break(1'b0)
`endif
  );

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_d (
    .clk(clk), .rstn(rstn), .tx_data(tdata[3]), .tx_valid(tvalid[3]),
    .tx_ready(rdy_v[3]), .fifo_level(lvl3), .busy(busy_v[3]), .tx_done(done_v[3]),
    .uart_tx(line_v[3])
`ifdef UART_TX_BREAK_EN
    , .tx_break(1'b0)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Start at a negedge. The task returns at the negedge after the accepting edge, with valid dropped.
  task automatic push(input int k, input logic [7:0] d);
    int t = 0;
    tdata[k]  = d;
    tvalid[k] = 1'b1;
    while (!rdy_v[k] && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check_val("push_timeout", t, 0);
    sb_q.push_back(d);
    @(negedge clk);
    tvalid[k] = 1'b0;
  endtask

  // Check one frame against the head of the scoreboard. The task returns at the
  // negedge just after the final stop boundary.
  task automatic rx_frame(input int k, input int nb, input int par, input int ns,
                          input int n_start, input int nxt);
    int t = 0;
    int bad = 0;
    int len;
    logic [7:0]  exp_d, mask, got;
    logic [11:0] bits;
    got = 8'h00;
    while (line_v[k] !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      check_val("start_timeout", t, 0);
      return;
    end
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 0, 1);
      return;
    end
    exp_d = sb_q.pop_front();
    mask  = 8'hFF >> (8 - nb);
    exp_d = exp_d & mask;
    len   = (1 + nb + ((par != 0) ? 1 : 0) + ns) * DIV;
    bits  = 12'hFFF;
    bits[0] = 1'b0;
    for (int i = 0; i < nb; i++) bits[1+i] = exp_d[i];
    if (par != 0) bits[1+nb] = (^exp_d) ^ (par == 1);
    for (int n = n_start; n < len; n++) begin
      if (line_v[k] !== bits[n/DIV]) bad++;
      if (busy_v[k] !== 1'b1) bad++;
      if (n > 0 && done_v[k] !== 1'b0) bad++;
      if (n % DIV == DIV / 2) begin
        if (n / DIV >= 1 && n / DIV <= nb) got[n/DIV-1] = line_v[k];
        if (par != 0 && n / DIV == nb + 1) last_par = line_v[k];
      end
      @(negedge clk);
    end
    check_val("frame_shape", bad, 0);
    check_val("rx_data", got, exp_d);
    check_val("tx_done", done_v[k], 1);
    check_val("busy_end", busy_v[k], nxt);
    check_val("line_end", line_v[k], (nxt != 0) ? 0 : 1);
  endtask

  initial begin
    int acc;
    int g;
    int bad;
    logic [7:0] w;
    rstn   = 1'b0;
    tvalid = 4'b0000;
    brk    = 1'b0;
    for (int i = 0; i < 4; i++) tdata[i] = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_line", line_v[0], 1);
    check_val("rst_busy", busy_v[0], 0);
    check_val("rst_done", done_v[0], 0);
    check_val("rst_level", lvl0, 0);
    check_val("rst_ready", rdy_v[0], 1);
    check_val("rst_ready_d", rdy_v[3], 1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // 8N1 single word 0x55
    push(0, 8'h55);
    check_val("latency_line", line_v[0], 1);
    check_val("level_one", lvl0, 1);
    rx_frame(0, 8, 0, 1, 0, 0);

    // three words on consecutive cycles; the first pop overlaps the second push
    push(0, 8'h01);
    check_val("lvl_p1", lvl0, 1);
    push(0, 8'h02);
    check_val("lvl_p2", lvl0, 1);
    push(0, 8'h03);
    check_val("lvl_peak", lvl0, 2);
    rx_frame(0, 8, 0, 1, 1, 1);
    rx_frame(0, 8, 0, 1, 0, 1);
    rx_frame(0, 8, 0, 1, 0, 0);

    // 7E2 and 7O2 with 0x25 (three ones)
    push(1, 8'h25);
    rx_frame(1, 7, 2, 2, 0, 0);
    check_val("even_parity", last_par, 1);
    push(2, 8'h25);
    rx_frame(2, 7, 1, 2, 0, 0);
    check_val("odd_parity", last_par, 0);

    // depth-4 FIFO, valid held for six cycles while the first frame runs
    acc = 0;
    w   = 8'h10;
    for (int i = 0; i < 6; i++) begin
      tdata[3]  = w;
      tvalid[3] = 1'b1;
      if (rdy_v[3]) begin
        sb_q.push_back(w);
        acc++;
        w = w + 8'h01;
      end
      @(negedge clk);
    end
    tvalid[3] = 1'b0;
    check_val("full_accepted", acc, 5);
    check_val("full_level", lvl3, 4);
    check_val("full_ready", rdy_v[3], 0);
    rx_frame(3, 8, 0, 1, 4, 1);
    for (int i = 0; i < 3; i++) rx_frame(3, 8, 0, 1, 0, 1);
    rx_frame(3, 8, 0, 1, 0, 0);

`ifdef UART_TX_BREAK_EN
    // a break raised mid-frame waits for the frame, then holds the line low
    push(0, 8'hA5);
    push(0, 8'h5A);
    fork
      rx_frame(0, 8, 0, 1, 0, 1);
      begin
        repeat (20) @(negedge clk);
        brk = 1'b1;
      end
    join
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (line_v[0] !== 1'b0 || busy_v[0] !== 1'b1) bad++;
      @(negedge clk);
    end
    check_val("break_low", bad, 0);
    brk = 1'b0;
    g = 0;
    @(negedge clk);
    while (line_v[0] === 1'b1 && g < 100) begin
      g++;
      @(negedge clk);
    end
    check_val("break_gap", g, DIV);
    rx_frame(0, 8, 0, 1, 0, 0);
`endif

    // reset in the middle of a frame, with a second word still queued
    push(0, 8'h5A);
    push(0, 8'h3C);
    check_val("pre_rst_level", lvl0, 1);
    repeat (35) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_val("mid_rst_line", line_v[0], 1);
    check_val("mid_rst_busy", busy_v[0], 0);
    check_val("mid_rst_level", lvl0, 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (line_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) bad++;
    end
    check_val("no_residual", bad, 0);
    check_val("post_rst_level", lvl0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
